// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: fetch PC, imem request channel,
// prefetch FIFO with PC tags and the IF/ID pipeline register.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        if_id_enable,
  input  logic        if_flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] pc_out,
  output logic [31:0] instrucao,
  output logic        instr_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   LIM  = DEPTH[CW:0];
  localparam logic [CW-1:0] FULL = DEPTH[CW-1:0];

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_tag    [DEPTH];
  logic [AW-1:0] r_tag_wr;
  logic [AW-1:0] r_tag_rd;
  logic [CW-1:0] r_outstanding;
  logic [31:0]   r_fq_pc  [DEPTH];
  logic [31:0]   r_fq_ins [DEPTH];
  logic [AW-1:0] r_fq_wr;
  logic [AW-1:0] r_fq_rd;
  logic [CW-1:0] r_fq_cnt;
  logic [CW-1:0] r_drop;
  logic [31:0]   r_pc_out;
  logic [31:0]   r_instr;
  logic          r_ivalid;

  logic [CW:0] w_used;
  logic        w_credit;
  logic        w_accept;
  logic        w_resp;
  logic        w_drop;
  logic        w_push;
  logic        w_load;
  logic        w_pop;
  logic        w_bubble;

  // Credits cover both in-flight requests and queued words.
  assign w_used   = {1'b0, r_outstanding} + {1'b0, r_fq_cnt};
  assign w_credit = w_used < LIM;

  assign imem_req_valid = reset & ~redirect_valid & w_credit;
  assign imem_req_addr  = r_fetch_pc;

  assign w_accept = imem_req_valid & imem_req_ready;
  assign w_resp   = imem_resp_valid & (r_outstanding != '0);
  assign w_drop   = w_resp & (r_drop != '0);
  assign w_push   = w_resp & ~w_drop & ~redirect_valid;
  assign w_load   = if_id_enable & ~if_flush & ~redirect_valid;
  assign w_pop    = w_load & (r_fq_cnt != '0);
  assign w_bubble = w_load & (r_fq_cnt == '0);

  assign pc_out      = r_pc_out;
  assign instrucao   = r_instr;
  assign instr_valid = r_ivalid;

  always_ff @(posedge clock) begin
    if (w_accept) r_tag[r_tag_wr] <= r_fetch_pc;
    if (w_push) begin
      r_fq_pc[r_fq_wr]  <= r_tag[r_tag_rd];
      r_fq_ins[r_fq_wr] <= imem_resp_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_tag_wr      <= '0;
      r_tag_rd      <= '0;
      r_outstanding <= '0;
      r_fq_wr       <= '0;
      r_fq_rd       <= '0;
      r_fq_cnt      <= '0;
      r_drop        <= '0;
      r_pc_out      <= '0;
      r_instr       <= NOP;
      r_ivalid      <= 1'b0;
    end else begin
      if (redirect_valid)
        r_fetch_pc <= redirect_pc;
      else if (w_accept)
        r_fetch_pc <= r_fetch_pc + 32'd4;

      if (w_accept) r_tag_wr <= r_tag_wr + 1'b1;
      if (w_resp)   r_tag_rd <= r_tag_rd + 1'b1;

      r_outstanding <= r_outstanding
                     + CW'(w_accept)
                     - CW'(w_resp);

      // No request is accepted in a redirect cycle.
      if (redirect_valid)
        r_drop <= r_outstanding - CW'(w_resp);
      else if (w_drop)
        r_drop <= r_drop - 1'b1;

      if (redirect_valid) begin
        r_fq_wr  <= '0;
        r_fq_rd  <= '0;
        r_fq_cnt <= '0;
      end else begin
        if (w_push) r_fq_wr <= r_fq_wr + 1'b1;
        if (w_pop)  r_fq_rd <= r_fq_rd + 1'b1;
        r_fq_cnt <= r_fq_cnt
                  + CW'(w_push)
                  - CW'(w_pop);
      end

      unique case (1'b1)
        if_flush: begin
          r_instr  <= NOP;
          r_ivalid <= 1'b0;
        end
        w_pop: begin
          r_pc_out <= r_fq_pc[r_fq_rd];
          r_instr  <= r_fq_ins[r_fq_rd];
          r_ivalid <= 1'b1;
        end
        w_bubble: begin
          r_instr  <= NOP;
          r_ivalid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clock) disable iff (!reset)
    !(w_push && r_fq_cnt == FULL)
  );

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: queue-based
// reference model plus an in-order variable-latency memory.
module tb_fetch_prefetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_id_enable = 1'b0;
  logic        if_flush = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic [31:0] pc_out;
  logic [31:0] instrucao;
  logic        instr_valid;

  always #5 clock = ~clock;

  fetch_prefetch_queue #(
    .DEPTH(DEPTH),
    .RESET_PC(32'h0000_0000),
    .NOP(NOP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_id_enable(if_id_enable),
    .if_flush(if_flush),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .pc_out(pc_out),
    .instrucao(instrucao),
    .instr_valid(instr_valid)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model
  logic [31:0] m_fpc;
  logic [31:0] m_pc;
  logic [31:0] m_ins;
  logic        m_v;
  logic [31:0] m_tags[$];
  logic [63:0] m_fifo[$];
  int          m_drop;

  // Memory model
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc;
  int          last_due;
  int          mem_lat;
  bit          mem_rand;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0060_0113;
    return a ^ 32'h5A5A_0013;
  endfunction

  function automatic logic m_req_v();
    return reset && !redirect_valid &&
           (m_tags.size() + m_fifo.size() < DEPTH);
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_id_enable = 1'b0;
    if_flush = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    m_fpc = 32'h0;
    m_pc = 32'h0;
    m_ins = NOP;
    m_v = 1'b0;
    m_tags.delete();
    m_fifo.delete();
    m_drop = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    cyc = 0;
    last_due = -1;
    mem_rand = 1'b0;
    mem_lat = 1;
  endtask

  task automatic drive(input logic rv, input logic [31:0] rpc,
                       input logic en, input logic fl,
                       input logic rdy);
    @(negedge clock);
    redirect_valid = rv;
    redirect_pc = rpc;
    if_id_enable = en;
    if_flush = fl;
    imem_req_ready = rdy;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data = memf(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data = $urandom;
    end
    #1;
  endtask

  task automatic tick();
    logic        acc;
    logic [31:0] tag;
    logic [63:0] e;
    int          due;
    acc = m_req_v() && imem_req_ready;
    if (if_flush) begin
      m_ins = NOP;
      m_v = 1'b0;
    end else if (!redirect_valid && if_id_enable) begin
      if (m_fifo.size() > 0) begin
        e = m_fifo.pop_front();
        m_pc = e[63:32];
        m_ins = e[31:0];
        m_v = 1'b1;
      end else begin
        m_ins = NOP;
        m_v = 1'b0;
      end
    end
    if (imem_resp_valid && m_tags.size() > 0) begin
      tag = m_tags.pop_front();
      if (m_drop > 0) m_drop--;
      else if (!redirect_valid)
        m_fifo.push_back({tag, imem_resp_data});
    end
    if (acc) begin
      m_tags.push_back(m_fpc);
      m_fpc = m_fpc + 32'd4;
    end
    if (redirect_valid) begin
      m_fifo.delete();
      m_drop = m_tags.size();
      m_fpc = redirect_pc;
    end
    if (imem_req_valid && imem_req_ready) begin
      due = cyc + (mem_rand ? int'($urandom_range(1, 4)) : mem_lat);
      if (due <= last_due) due = last_due + 1;
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(due);
      last_due = due;
    end
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clock);
    #1;
    n_chk++;
    if (instr_valid !== 1'b0 || instrucao !== NOP ||
        pc_out !== 32'h0 || imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state v=%b ins=%h pc=%h req=%b expected 0/%h/0/0",
               instr_valid, instrucao, pc_out, imem_req_valid, NOP);
    end
    do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_release_req valid=%b addr=%h expected 1/0",
               imem_req_valid, imem_req_addr);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] hp[8];
    logic [31:0] hi[8];
    logic        hv[8];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      n_chk++;
      if (imem_req_valid !== m_req_v() || imem_req_addr !== m_fpc) begin
        n_fail++;
        $display("FAIL basic_req i=%0d got %b/%h expected %b/%h",
                 i, imem_req_valid, imem_req_addr, m_req_v(), m_fpc);
      end
      tick();
      hp[i] = pc_out;
      hi[i] = instrucao;
      hv[i] = instr_valid;
    end
    n_chk++;
    if (hv[1] !== 1'b0 || hv[2] !== 1'b1 || hp[2] !== 32'h0 ||
        hi[2] !== 32'h0050_0093) begin
      n_fail++;
      $display("FAIL basic_first v1=%b v2=%b pc=%h ins=%h expected 0/1/0/00500093",
               hv[1], hv[2], hp[2], hi[2]);
    end
    n_chk++;
    if (hv[3] !== 1'b1 || hp[3] !== 32'h4 || hi[3] !== 32'h0060_0113) begin
      n_fail++;
      $display("FAIL basic_second v=%b pc=%h ins=%h expected 1/4/00600113",
               hv[3], hp[3], hi[3]);
    end
    n_chk++;
    if (hv[7] !== 1'b1 || hp[7] !== 32'h14) begin
      n_fail++;
      $display("FAIL basic_throughput v=%b pc=%h expected 1/14", hv[7], hp[7]);
    end
  endtask

  task automatic test_no_ready();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      n_chk++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
        n_fail++;
        $display("FAIL noready_req i=%0d got %b/%h expected 1/0",
                 i, imem_req_valid, imem_req_addr);
      end
      tick();
      n_chk++;
      if (instr_valid !== 1'b0 || instrucao !== NOP) begin
        n_fail++;
        $display("FAIL noready_bubble i=%0d got %b/%h expected 0/%h",
                 i, instr_valid, instrucao, NOP);
      end
    end
  endtask

  task automatic test_stall();
    int          acc;
    logic [31:0] seen[$];
    do_reset();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      if (imem_req_valid && imem_req_ready) acc++;
      tick();
      n_chk++;
      if (pc_out !== m_pc || instr_valid !== m_v || instrucao !== m_ins) begin
        n_fail++;
        $display("FAIL stall_hold i=%0d got %h/%b expected %h/%b",
                 i, pc_out, instr_valid, m_pc, m_v);
      end
    end
    n_chk++;
    if (acc != 4) begin
      n_fail++;
      $display("FAIL stall_accepts got %0d expected 4", acc);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      if (i == 0) begin
        n_chk++;
        if (imem_req_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_credit valid=%b expected 0", imem_req_valid);
        end
      end
      tick();
      if (instr_valid) seen.push_back(pc_out);
    end
    n_chk++;
    if (seen.size() < 4 || seen[0] !== 32'h0 || seen[1] !== 32'h4 ||
        seen[2] !== 32'h8 || seen[3] !== 32'hC) begin
      n_fail++;
      $display("FAIL stall_order got %p expected 0,4,8,c first", seen);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] first;
    logic        got;
    do_reset();
    mem_lat = 3;
    repeat (2) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 32'h100, 1'b1, 1'b1, 1'b1);
    n_chk++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_noreq valid=%b expected 0", imem_req_valid);
    end
    tick();
    n_chk++;
    if (instr_valid !== 1'b0 || instrucao !== NOP) begin
      n_fail++;
      $display("FAIL redir_flush got %b/%h expected 0/%h",
               instr_valid, instrucao, NOP);
    end
    got = 1'b0;
    first = '0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      if (i == 0) begin
        n_chk++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
          n_fail++;
          $display("FAIL redir_addr got %b/%h expected 1/100",
                   imem_req_valid, imem_req_addr);
        end
      end
      tick();
      n_chk++;
      if (pc_out !== m_pc || instr_valid !== m_v || instrucao !== m_ins) begin
        n_fail++;
        $display("FAIL redir_ifid i=%0d got %h/%b expected %h/%b",
                 i, pc_out, instr_valid, m_pc, m_v);
      end
      if (instr_valid && !got) begin
        got = 1'b1;
        first = pc_out;
      end
    end
    n_chk++;
    if (!got || first !== 32'h100) begin
      n_fail++;
      $display("FAIL redir_first got %b/%h expected 1/100", got, first);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] first;
    logic        got;
    logic        leak;
    do_reset();
    mem_lat = 2;
    repeat (3) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      tick();
    end
    drive(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b1, 32'h300, 1'b1, 1'b1, 1'b1);
    tick();
    got = 1'b0;
    leak = 1'b0;
    first = '0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      n_chk++;
      if (imem_req_valid !== m_req_v() || imem_req_addr !== m_fpc) begin
        n_fail++;
        $display("FAIL b2b_req i=%0d got %b/%h expected %b/%h",
                 i, imem_req_valid, imem_req_addr, m_req_v(), m_fpc);
      end
      tick();
      if (instr_valid && pc_out >= 32'h200 && pc_out < 32'h300) leak = 1'b1;
      if (instr_valid && !got) begin
        got = 1'b1;
        first = pc_out;
      end
    end
    n_chk++;
    if (leak || !got || first !== 32'h300) begin
      n_fail++;
      $display("FAIL b2b_first leak=%b got=%b pc=%h expected 0/1/300",
               leak, got, first);
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_pre got %b/%h expected 1/fffffffc",
               imem_req_valid, imem_req_addr);
    end
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_post got %b/%h expected 1/0",
               imem_req_valid, imem_req_addr);
    end
    tick();
    repeat (3) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      tick();
    end
    n_chk++;
    if (instr_valid !== 1'b1 || pc_out !== m_pc) begin
      n_fail++;
      $display("FAIL wrap_stream got %b/%h expected 1/%h",
               instr_valid, pc_out, m_pc);
    end
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if (instr_valid !== 1'b0 || instrucao !== NOP ||
        imem_req_valid !== 1'b0 || pc_out !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset got %b/%h/%b/%h expected 0/%h/0/0",
               instr_valid, instrucao, imem_req_valid, pc_out, NOP);
    end
  endtask

  task automatic test_random();
    logic        rv;
    logic        fl;
    logic [31:0] r;
    do_reset();
    mem_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 19) == 0);
      fl = rv ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 29) == 0);
      r = $urandom;
      drive(rv, r & 32'hFFFF_FFFC, ($urandom_range(0, 3) != 0), fl,
            ($urandom_range(0, 3) != 0));
      n_chk++;
      if (imem_req_valid !== m_req_v() || imem_req_addr !== m_fpc) begin
        n_fail++;
        $display("FAIL rand_req i=%0d got %b/%h expected %b/%h",
                 i, imem_req_valid, imem_req_addr, m_req_v(), m_fpc);
      end
      tick();
      n_chk++;
      if (pc_out !== m_pc || instr_valid !== m_v || instrucao !== m_ins) begin
        n_fail++;
        $display("FAIL rand_ifid i=%0d got %h/%h/%b expected %h/%h/%b",
                 i, pc_out, instrucao, instr_valid, m_pc, m_ins, m_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_ready();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
